// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, completer state encoding and helpers
package apb_pkg;

  localparam int APB_ADDR_W    = 9;
  localparam int APB_DATA_W    = 8;
  localparam int SLAVE_SEL_BIT = 8;

  // One-hot completer phase encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ACCESS = 3'b010,
    S_ERR    = 3'b100
  } state_t;

  // Error counter increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between requester and completer
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - byte register memory, sync write, async read and clear
module apb_slave_regfile #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  logic [7:0] mem_q [DEPTH];

  // Whole array clears on reset; otherwise one in-range location is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we && ({1'b0, waddr} < DEPTH_W)) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  // Out-of-range reads return zero rather than indexing past the array
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < DEPTH_W) rdata = mem_q[raddr[AW-1:0]];
  end

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with wait states, error response and error count
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_slave_mem_if.slave   apb,
  output logic [7:0]       err_cnt
);

  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic [8:0] DEPTH_W = 9'(MEM_DEPTH);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] addr_q;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic       bad_q;
  logic [7:0] prdata_q;
  logic [7:0] err_cnt_q;

  logic [7:0] idx_in;
  logic       unused_sel_bit;
  logic       in_range_in;
  logic       setup;
  logic       access;
  logic       mismatch;
  logic       done;
  logic       bad_eff;
  logic       mem_we;
  logic [7:0] rd_data;

  // The bridge's slave-select bit never reaches the index decode
  assign idx_in         = apb.PADDR[7:0];
  assign unused_sel_bit = apb.PADDR[SLAVE_SEL_BIT];
  assign in_range_in    = ({1'b0, idx_in} < DEPTH_W);
  assign setup          = apb.PSEL && !apb.PENABLE;
  assign access         = apb.PSEL && apb.PENABLE;
  assign mismatch       = (idx_in != addr_q) || (apb.PWRITE != wr_q);
  assign done           = (state_q == S_ACCESS) && access && (cnt_q == 4'd0);
  // A request that drifts on the completing edge still must not commit
  assign bad_eff        = bad_q || mismatch;
  assign mem_we         = done && wr_q && !bad_eff;

  apb_slave_regfile #(.DEPTH(MEM_DEPTH)) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (idx_in),
    .rdata (rd_data)
  );

  // Phase tracking, wait countdown, request latching and error accounting
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      bad_q     <= 1'b0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (setup) begin
            addr_q  <= idx_in;
            wr_q    <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
            cnt_q   <= WS;
            bad_q   <= !in_range_in;
            if (!apb.PWRITE) prdata_q <= in_range_in ? rd_data : 8'h00;
            state_q <= S_ACCESS;
          end else if (access) begin
            state_q <= S_ERR;
          end
        end
        S_ACCESS: begin
          if (!access) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
            state_q   <= S_IDLE;
          end else begin
            if (mismatch) begin
              bad_q <= 1'b1;
              if (!wr_q) prdata_q <= 8'h00;
            end
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              if (bad_eff) err_cnt_q <= sat_inc8(err_cnt_q);
              state_q <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          err_cnt_q <= sat_inc8(err_cnt_q);
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = ((state_q == S_ACCESS) && (cnt_q == 4'd0)) || (state_q == S_ERR);
  assign apb.PSLVERR = ((state_q == S_ACCESS) && (cnt_q == 4'd0) && bad_q) || (state_q == S_ERR);
  assign err_cnt     = err_cnt_q;

endmodule
